posit_div_issue_ctrl: RTL and testbench

//  Flow-control shell around the fixed-latency posit divider, which has no backpressure.

---
 rtl/posit_div_issue_ctrl.sv | 179 +++++++++++++++++
 tb/tb_posit_div_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_div_issue_ctrl.sv
// Valid/ready flow-control shell around a fixed-latency posit divider with no backpressure.
// Optional statistics counters are enabled with the POSIT_DIV_STATS_EN macro.
module posit_div_issue_ctrl #(
  parameter int N     = 16,
  parameter int TAGW  = 4,
  parameter int LAT   = 12,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic [N-1:0]    div_a,
  output logic [N-1:0]    div_b,
  output logic            div_start,
  input  logic [N-1:0]    div_r,
  input  logic            div_inf,
  input  logic            div_zero,
  input  logic            div_done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_r,
  output logic            out_inf,
  output logic            out_zero,
  output logic [TAGW-1:0] out_tag,
  output logic            proto_err
`ifdef POSIT_DIV_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [15:0]     stat_inf,
  output logic [15:0]     stat_zero
`endif
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int FCW = $clog2(LAT) + 1;
  localparam int EW  = TAGW + N + 2;

  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [LAT-1:0]  r_pipe_vld;
  logic [TAGW-1:0] r_pipe_tag [LAT];
  logic            r_flushing;
  logic [FCW-1:0]  r_flush_cnt;
  logic            r_proto_err;

  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic [CW:0]     w_used;
  logic [EW-1:0]   w_head;

  // Sum is one bit wider than either counter so it can never wrap.
  assign w_used    = {1'b0, r_inflight} + {1'b0, r_count};
  assign in_ready  = !r_flushing && (w_used < (CW+1)'(DEPTH));
  assign w_issue   = in_valid & in_ready;
  assign div_start = w_issue;
  assign div_a     = in_a;
  assign div_b     = in_b;

  assign w_push    = div_done & r_pipe_vld[LAT-1];
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_full    = (r_count == CW'(DEPTH));

  assign w_head    = r_mem[r_rd_ptr];
  assign out_tag   = w_head[EW-1 -: TAGW];
  assign out_r     = w_head[N+1:2];
  assign out_inf   = w_head[1];
  assign out_zero  = w_head[0];
  assign proto_err = r_proto_err;

  // The divider cannot be reset, so its pipeline is drained for LAT cycles after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flushing  <= 1'b1;
      r_flush_cnt <= '0;
    end else if (r_flushing) begin
      r_flush_cnt <= r_flush_cnt + FCW'(1);
      if (r_flush_cnt == FCW'(LAT-1)) r_flushing <= 1'b0;
    end
  end

  // Tag pipe mirrors the divider latency; its exit stage lines up with div_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < LAT; i++) r_pipe_tag[i] <= '0;
    end else begin
      r_pipe_vld    <= {r_pipe_vld[LAT-2:0], w_issue};
      r_pipe_tag[0] <= in_tag;
      for (int i = 1; i < LAT; i++) r_pipe_tag[i] <= r_pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_pipe_tag[LAT-1], div_r, div_inf, div_zero};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (div_done && !r_pipe_vld[LAT-1] && !r_flushing) begin
      r_proto_err <= 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full && !w_pop));

`ifdef POSIT_DIV_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] r_stat_issued;
  logic [15:0] r_stat_inf;
  logic [15:0] r_stat_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_issued <= '0;
      r_stat_inf    <= '0;
      r_stat_zero   <= '0;
    end else begin
      if (w_issue)             r_stat_issued <= sat_inc32(r_stat_issued);
      if (w_push && div_inf)   r_stat_inf    <= sat_inc16(r_stat_inf);
      if (w_push && div_zero)  r_stat_zero   <= sat_inc16(r_stat_zero);
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_inf    = r_stat_inf;
  assign stat_zero   = r_stat_zero;
`else
`endif

endmodule

// File: tb/tb_posit_div_issue_ctrl.sv
// Bench for posit_div_issue_ctrl: a behavioural fixed-latency divider stub plus
// table-driven single-result vectors and hand-written backpressure/reset/error sequences.
module tb_posit_div_issue_ctrl;
  localparam int N     = 16;
  localparam int TAGW  = 4;
  localparam int LAT   = 12;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N-1:0]    in_a = '0;
  logic [N-1:0]    in_b = '0;
  logic [TAGW-1:0] in_tag = '0;
  logic [N-1:0]    div_a;
  logic [N-1:0]    div_b;
  logic            div_start;
  logic [N-1:0]    div_r;
  logic            div_inf;
  logic            div_zero;
  logic            div_done;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N-1:0]    out_r;
  logic            out_inf;
  logic            out_zero;
  logic [TAGW-1:0] out_tag;
  logic            proto_err;
`ifdef POSIT_DIV_STATS_EN
  logic [31:0]     stat_issued;
  logic [15:0]     stat_inf;
  logic [15:0]     stat_zero;
`endif

  posit_div_issue_ctrl #(.N(N), .TAGW(TAGW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_r(div_r), .div_inf(div_inf), .div_zero(div_zero), .div_done(div_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_inf(out_inf),
    .out_zero(out_zero), .out_tag(out_tag), .proto_err(proto_err)
`ifdef POSIT_DIV_STATS_EN
    , .stat_issued(stat_issued), .stat_inf(stat_inf), .stat_zero(stat_zero)
`endif
  );

  // Divider stub: posit16 results for the operand pairs used here, {inf, zero, r}.
  function automatic logic [17:0] div_model(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'h0000) return {2'b10, 16'h8000};
    if (a == 16'h0000) return {2'b01, 16'h0000};
    if (a == 16'h4000 && b == 16'h5000) return {2'b00, 16'h3000};
    if (b == 16'h4000) return {2'b00, a};
    return {2'b00, 16'h0000};
  endfunction

  logic [LAT-1:0] s_vld = '0;
  logic [15:0]    s_a [LAT];
  logic [15:0]    s_b [LAT];
  logic           inj = 1'b0;
  logic [17:0]    s_res;

  always @(posedge clk) begin
    s_vld  <= {s_vld[LAT-2:0], div_start};
    s_a[0] <= div_a;
    s_b[0] <= div_b;
    for (int i = 1; i < LAT; i++) begin
      s_a[i] <= s_a[i-1];
      s_b[i] <= s_b[i-1];
    end
  end

  assign s_res    = div_model(s_a[LAT-1], s_b[LAT-1]);
  assign div_done = s_vld[LAT-1] | inj;
  assign div_inf  = s_res[17];
  assign div_zero = s_res[16];
  assign div_r    = s_res[15:0];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic do_reset(input int hold);
    int bad;
    @(negedge clk);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    in_valid = 1'b0;
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < LAT; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || proto_err !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("flush_window_quiet", bad, 0);
    chk("flush_end_in_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [15:0] er;
    logic        einf;
    logic        ezero;
  } vec_t;

  vec_t vt [4];

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    in_valid = 1'b1; in_a = v.a; in_b = v.b; in_tag = v.tag; out_ready = 1'b1;
    chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
    lat = -1;
    for (int k = 1; k <= 3*LAT; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (out_valid === 1'b1) begin lat = k; break; end
    end
    chk($sformatf("v%0d_latency", idx), lat, LAT+1);
    chk($sformatf("v%0d_r", idx), out_r, v.er);
    chk($sformatf("v%0d_tag", idx), out_tag, v.tag);
    chk($sformatf("v%0d_inf", idx), out_inf, v.einf);
    chk($sformatf("v%0d_zero", idx), out_zero, v.ezero);
  endtask

  // Expects cnt results with consecutive tags from tag0 and r = 0x4100 + tag.
  task automatic drain(input int cnt, input int tag0, input string nm);
    int got, bad;
    got = 0; bad = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 4*LAT && got < cnt; k++) begin
      if (out_valid === 1'b1) begin
        if (out_tag !== 4'(tag0 + got) || out_r !== 16'h4100 + 16'(tag0 + got)) bad++;
        got++;
      end
      @(negedge clk);
    end
    chk({nm, "_count"}, got, cnt);
    chk({nm, "_order"}, bad, 0);
    repeat (2) @(negedge clk);
    chk({nm, "_no_extra"}, out_valid, 0);
    chk({nm, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int acc, bad;
    logic [15:0] held_r;
    logic [3:0]  held_tag;

    vt[0] = '{a: 16'h4000, b: 16'h5000, tag: 4'd3, er: 16'h3000, einf: 1'b0, ezero: 1'b0};
    vt[1] = '{a: 16'h4000, b: 16'h0000, tag: 4'd5, er: 16'h8000, einf: 1'b1, ezero: 1'b0};
    vt[2] = '{a: 16'h0000, b: 16'h4000, tag: 4'd6, er: 16'h0000, einf: 1'b0, ezero: 1'b1};
    vt[3] = '{a: 16'h5000, b: 16'h4000, tag: 4'd9, er: 16'h5000, einf: 1'b0, ezero: 1'b0};

    do_reset(2);

    for (int i = 0; i < 4; i++) run_vec(vt[i], i);
    @(negedge clk);
    chk("vec_proto_err", proto_err, 0);

    // Back-to-back issue with the consumer stalled.
    out_ready = 1'b0; in_valid = 1'b1; in_b = 16'h4000; acc = 0;
    in_tag = 4'd0; in_a = 16'h4100;
    for (int c = 0; c < 3*LAT; c++) begin
      logic acc_now;
      acc_now = in_ready;
      @(negedge clk);
      if (acc_now) begin
        acc++;
        in_tag = 4'(acc);
        in_a = 16'h4100 + 16'(acc);
      end
    end
    in_valid = 1'b0;
    chk("fill_accepts", acc, DEPTH);
    chk("fill_in_ready_low", in_ready, 0);
    chk("fill_out_valid", out_valid, 1);
    held_r = out_r; held_tag = out_tag;
    @(negedge clk);
    chk("stall_hold_r", out_r, held_r);
    chk("stall_hold_tag", out_tag, held_tag);
    drain(DEPTH, 0, "drain3");

    // Last done lands in the same cycle the consumer starts popping.
    out_ready = 1'b0; in_valid = 1'b1; in_b = 16'h4000; bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_tag = 4'(4 + i);
      in_a = 16'h4100 + 16'(4 + i);
      if (in_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t4_issue_ready", bad, 0);
    repeat (LAT-1) @(negedge clk);
    chk("t4_in_ready_full_credit", in_ready, 0);
    chk("t4_done_now", div_done, 1);
    chk("t4_head_tag", out_tag, 4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_head_advanced", out_tag, 5);
    chk("t4_in_ready_after", in_ready, 1);
    drain(DEPTH-1, 5, "drain4");

    // Reset with three results still inside the divider.
    out_ready = 1'b1; in_valid = 1'b1; in_b = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      in_tag = 4'(1 + i);
      in_a = 16'h4100 + 16'(1 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    do_reset(1);
    bad = 0;
    for (int i = 0; i < 2*LAT; i++) begin
      if (out_valid !== 1'b0 || proto_err !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("midreset_nothing_out", bad, 0);
    run_vec(vt[0], 4);

    // Spurious done after the flush window.
    repeat (2) @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("spurious_proto_err", proto_err, 1);
    chk("spurious_no_push", out_valid, 0);
    repeat (5) @(negedge clk);
    chk("spurious_sticky", proto_err, 1);
    chk("spurious_no_push_later", out_valid, 0);
    do_reset(1);
    chk("proto_err_cleared", proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
